// File: rtl/lc3_bus_reader.sv
// Receiving end of the LC-3 shared data bus: round-robin gate arbiter with a
// turnaround cycle, bus capture, and a small tagged FIFO on a valid/ready port.
module lc3_bus_reader #(
    parameter int N_SRC = 4,
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int SW    = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] req,
    output logic [N_SRC-1:0] gate,
    output logic [N_SRC-1:0] ack,
    input  logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE} state_t;

    typedef struct packed {
        logic [SW-1:0]    src;
        logic [WIDTH-1:0] data;
    } entry_t;

    state_t         state;
    logic [SW-1:0]  ptr;
    logic [SW-1:0]  winner;
    logic [SW-1:0]  pick;
    logic [SW-1:0]  cand;
    logic           pick_valid;

    entry_t         mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;
    logic           fifo_room;
    entry_t         head;

    function automatic logic [SW-1:0] src_inc(input logic [SW-1:0] v);
        return (v == SW'(N_SRC - 1)) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [PW-1:0] slot_inc(input logic [PW-1:0] v);
        return (v == PW'(DEPTH - 1)) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [N_SRC-1:0] onehot(input logic [SW-1:0] i);
        return N_SRC'(1) << i;
    endfunction

    // Round-robin search: first requester strictly after the last winner.
    // NOTE: every signal in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = ptr;
        for (int k = 0; k < N_SRC; k++) begin
            cand = src_inc(cand);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    assign push      = (state == SAMPLE);
    assign pop       = out_valid && out_ready;
    assign fifo_room = (count < CW'(DEPTH));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gate   <= '0;
            ack    <= '0;
            busy   <= 1'b0;
            ptr    <= SW'(N_SRC - 1);
            winner <= '0;
        end else begin
            ack <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_valid && fifo_room) begin
                        winner <= pick;
                        gate   <= onehot(pick);
                        busy   <= 1'b1;
                        state  <= DRIVE;
                    end
                end
                DRIVE: state <= SAMPLE;
                SAMPLE: begin
                    ack   <= onehot(winner);
                    gate  <= '0;
                    busy  <= 1'b0;
                    ptr   <= winner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= slot_inc(wr_ptr);
            if (pop)  rd_ptr <= slot_inc(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is not reset; occupancy lives in count, and the output mux hides stale slots.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{src: winner, data: bus};
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? head.data : '0;
    assign out_src   = out_valid ? head.src  : '0;

endmodule

// File: tb/tb_lc3_bus_reader.sv
// Bench for lc3_bus_reader: directed scenarios plus random traffic, checked by a
// negedge monitor against a transaction-level round-robin/FIFO model.
module tb_lc3_bus_reader;

    localparam int N = 4;
    localparam int W = 16;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] gate;
    logic [N-1:0] ack;
    logic [W-1:0] bus;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    lc3_bus_reader #(.N_SRC(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gate(gate), .ack(ack), .bus(bus),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver-side bus model: the gated source drives its word, otherwise junk.
    logic [W-1:0] src_data [N];
    logic [W-1:0] junk;
    bit           rand_mode;

    always_comb begin
        bus = junk;
        for (int i = 0; i < N; i++)
            if (gate[i]) bus = src_data[i];
    end

    // Reference model state.
    typedef struct {int src; logic [W-1:0] data;} exp_t;
    exp_t         sb[$];
    int           grant_log[$];
    int           model_ptr;
    int           cur_win;
    logic [W-1:0] cur_data;
    int           gate_len;
    int           prev_size;
    logic [N-1:0] gate_prev;
    logic [N-1:0] req_prev;

    function automatic int rr_pick(input int p, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int w);
        return (w < 0) ? '0 : N'(1) << w;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            model_ptr = N - 1;
            gate_prev = '0;
            req_prev  = req;
            prev_size = 0;
            gate_len  = 0;
        end else begin
            int   w;
            int   nsize;
            exp_t e;
            check("busy", busy, gate != 0);
            check("gate_onehot", $countones(gate) <= 1, 1);
            if (gate_prev != 0 && gate == 0) begin
                check("gate_len", gate_len, 2);
                check("ack_pulse", ack, oh(cur_win));
                sb.push_back('{cur_win, cur_data});
                model_ptr = cur_win;
            end else begin
                check("ack_quiet", ack, 0);
            end
            if (gate_prev == 0 && gate != 0) begin
                w = rr_pick(model_ptr, req_prev);
                check("grant", gate, oh(w));
                check("grant_not_full", prev_size < D, 1);
                cur_win  = w;
                cur_data = (w >= 0) ? src_data[w] : '0;
                grant_log.push_back(w);
                gate_len = 1;
            end else if (gate != 0) begin
                check("gate_hold", gate, gate_prev);
                gate_len++;
            end else if (gate_prev == 0) begin
                check("missed_grant", req_prev != 0 && prev_size < D, 0);
            end
            check("out_valid", out_valid, sb.size() != 0);
            nsize = sb.size();
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                check("out_data", out_data, e.data);
                check("out_src", out_src, e.src);
            end
            prev_size = nsize;
            req_prev  = req;
            gate_prev = gate;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        junk = W'($urandom);
        if (rand_mode) begin
            out_ready = ($urandom_range(9) < 7);
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    src_data[i] = W'($urandom);
                    req[i]      = $urandom_range(1);
                end else if (gate[i] && $urandom_range(7) == 0) begin
                    req[i] = 1'b0;
                end else if (!req[i] && !gate[i] && $urandom_range(3) == 0) begin
                    req[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_ack(input int i);
        int n = 0;
        while (!ack[i] && n < 100) begin step(); n++; end
        check("ack_timeout", ack[i], 1);
    endtask

    task automatic wait_gate(input int i);
        int n = 0;
        while (!gate[i] && n < 100) begin step(); n++; end
        check("gate_timeout", gate[i], 1);
    endtask

    task automatic drain();
        int  n = 0;
        bit  done = 0;
        rand_mode = 0;
        req       = '0;
        out_ready = 1'b1;
        while (!done && n < 200) begin
            step();
            n++;
            done = (sb.size() == 0) && !out_valid && gate == 0 && !busy;
        end
        check("drain", done, 1);
    endtask

    initial begin
        int acks;
        int base;
        rst_n     = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        rand_mode = 0;
        junk      = '0;
        for (int i = 0; i < N; i++) src_data[i] = '0;
        #1;
        check("rst_gate", gate, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        #20;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) step();
        check("idle_gate", gate, 0);
        check("idle_valid", out_valid, 0);

        // Round-robin with every source requesting, starting from reset priority.
        for (int i = 0; i < N; i++) src_data[i] = 16'hA000 + W'(i);
        out_ready = 1'b1;
        req       = 4'b1111;
        acks      = 0;
        base      = grant_log.size();
        for (int n = 0; n < 200 && acks < 5; n++) begin
            step();
            if (ack != 0) acks++;
        end
        req = '0;
        check("rr_acks", acks, 5);
        drain();
        check("rr_count", grant_log.size() - base, 5);
        for (int k = 0; k < 5; k++)
            if (base + k < grant_log.size())
                check("rr_order", grant_log[base + k], k % N);

        // Single transfer from source 2.
        src_data[2] = 16'h1234;
        req         = 4'b0100;
        wait_gate(2);
        check("single_gate", gate, 4'b0100);
        wait_ack(2);
        req = '0;
        check("single_gate_off", gate, 0);
        drain();

        // Backpressure: two words fill the FIFO, then no grant until a pop.
        src_data[0] = 16'h0B00;
        src_data[1] = 16'h0B01;
        out_ready   = 1'b0;
        req         = 4'b0011;
        base        = grant_log.size();
        repeat (20) step();
        check("bp_grants", grant_log.size() - base, 2);
        check("bp_valid", out_valid, 1);
        check("bp_head_data", out_data, 16'h0B00);
        check("bp_head_src", out_src, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (6) step();
        check("bp_regrant", grant_log.size() - base, 3);
        check("bp_head_next", out_data, 16'h0B01);
        drain();

        // Withdrawal of REQ during DRIVE; next grant follows pointer=1.
        src_data[1] = 16'hBEEF;
        out_ready   = 1'b1;
        req         = 4'b0010;
        wait_gate(1);
        req = '0;
        wait_ack(1);
        req = 4'b1111;
        wait_gate(2);
        req = '0;
        drain();

        // Random traffic.
        rand_mode = 1;
        repeat (1500) step();
        drain();

        // Reset in DRIVE clears everything at once and restores priority.
        req = 4'b0100;
        wait_gate(2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_gate", gate, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_src", out_src, 0);
        req = '0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();
        check("post_rst_valid", out_valid, 0);
        req = 4'b1111;
        wait_gate(0);
        req = '0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lc3_bus_reader.md
Name: lc3_bus_reader

Overview:
- Receiving end of the LC-3 shared 16-bit tristate data bus.
- Arbitrates among N_SRC bus drivers and issues the one-hot gate enables that feed each driver's SEL input.
- Samples the resolved bus value and enforces a turnaround cycle so no two drivers ever overlap.
- Queues captured words in a small FIFO and presents them downstream on a valid/ready handshake, tagged with the source index.

Parameters:
- N_SRC, 4, number of bus drivers (GATE/REQ/ACK width); N_SRC >= 2.
- WIDTH, 16, bus data width.
- DEPTH, 2, capture FIFO entries; DEPTH >= 1.
- SW, $clog2(N_SRC), width of source tag.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- REQ  input  N_SRC  per-source level request to drive the bus.
- GATE  output  N_SRC  one-hot (or zero) registered enable to driver SEL inputs.
- ACK  output  N_SRC  one-cycle pulse to the source whose word was captured.
- BUS  input  WIDTH  resolved shared bus value.
- OUT_DATA  output  WIDTH  head-of-FIFO data.
- OUT_SRC  output  SW  source index of head entry.
- OUT_VALID  output  1  FIFO non-empty.
- OUT_READY  input  1  downstream accepts head when high with OUT_VALID.
- BUSY  output  1  high while GATE is non-zero.

Behaviour:
- Reset (RST_N low, asynchronous, effective immediately even mid-transfer):
  - GATE=0, ACK=0, BUSY=0, OUT_VALID=0, OUT_DATA=0, OUT_SRC=0.
  - FIFO emptied; state=IDLE; round-robin pointer=N_SRC-1, so source 0 has first priority.
- FSM, all outputs registered:
  - IDLE: if REQ!=0 and fifo_count<DEPTH, select the winner, set GATE=onehot(winner) and BUSY=1, go DRIVE. Otherwise stay in IDLE with GATE=0.
  - DRIVE: one settle cycle with GATE held; go SAMPLE.
  - SAMPLE: GATE held. At the end-of-cycle edge: push {winner, BUS} into the FIFO, pulse ACK[winner] for exactly the next cycle, set GATE=0 and BUSY=0, update pointer=winner, go IDLE.
- Timing guarantees:
  - GATE is high for exactly 2 cycles per transfer.
  - GATE is 0 for at least 1 cycle between transfers (bus turnaround).
  - Minimum 3 cycles per word.
  - GATE is never multi-hot.
- Arbitration:
  - Round-robin; search starts at pointer+1 mod N_SRC.
  - REQ is sampled only in IDLE; changes during DRIVE/SAMPLE are ignored.
  - A source withdrawing REQ mid-transfer still has its word captured and receives ACK.
  - Sources hold REQ until ACK. REQ still high on the cycle after ACK counts as a new request.
- FIFO:
  - Push in the SAMPLE edge, pop when OUT_VALID&&OUT_READY.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Full (count==DEPTH): no new grant starts.
  - An in-flight transfer always has a free slot, because a grant requires count<DEPTH and only one transfer is in flight at a time.
  - OUT_DATA/OUT_SRC stay stable while OUT_VALID&&!OUT_READY.
  - OUT_DATA/OUT_SRC show the head entry. When the FIFO is empty, OUT_VALID=0 and OUT_DATA/OUT_SRC are don't-care.
- Widths:
  - BUS is captured verbatim; no arithmetic.
  - Pointer increment wraps modulo N_SRC (non-power-of-two N_SRC supported).

Test Plan:
- Reset/idle: RST_N=0 then 1 with REQ=0 -> GATE=0, OUT_VALID=0, BUSY=0 indefinitely. Assert RST_N=0 in DRIVE -> GATE=0 before the next edge, FIFO empty.
- Single transfer: REQ=4'b0100, driver 2 puts 16'h1234 on BUS while GATE[2]=1, OUT_READY=1 ->
  - GATE=4'b0100 for 2 cycles;
  - ACK[2] pulses 1 cycle;
  - OUT_VALID=1 with OUT_DATA=16'h1234, OUT_SRC=2;
  - GATE=0 for at least 1 cycle afterwards.
- Round-robin: REQ=4'b1111 held, drivers put 16'hA000+index on BUS, OUT_READY=1 -> grant order 0,1,2,3,0, and OUT_DATA sequence A000, A001, A002, A003, A000.
- Backpressure: OUT_READY=0, REQ=4'b0011, DEPTH=2 ->
  - two words captured, then no further GATE while full;
  - OUT_DATA holds the first word;
  - raising OUT_READY for 1 cycle pops it and a new grant starts on the next IDLE cycle.
- Simultaneous push/pop: FIFO holds 1 entry, OUT_READY=1 during a SAMPLE edge -> count stays 1, outputs advance in order with no loss or duplicate.
- Mid-transfer withdrawal: REQ[1] dropped during DRIVE with BUS=16'hBEEF -> word 16'hBEEF from source 1 still captured, ACK[1] pulses, the next grant follows pointer=1.
